// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift engine: a command FIFO feeds an IDLE/SETUP/SHIFT/HOLD/GAP sequencer
// driving three active-low chip selects, sck and mosi, and returning each byte read from miso.
module spi_shift_engine #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Bus2IP_Clk,
    input  logic       Bus2IP_Resetn,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       lcd_csn,
    output logic       sdcard_csn,
    output logic       flash_csn,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic [2:0] state_dbg
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
    logic [9:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;
    logic [9:0]    fifo_head;
    logic [1:0]    head_dev;

    state_t     state;
    logic [7:0] div_cnt;
    logic [3:0] half_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [1:0] cur_dev;
    logic [2:0] csn_vec;
    logic       div_done;
    logic       hold_end;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FIFO_FULL);
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr];
    assign head_dev   = fifo_head[9:8];

    assign div_done = (div_cnt == DIV_LAST);
    assign hold_end = (state == HOLD) && div_done;
    // A release (00) head is consumed both from IDLE and at the end of HOLD.
    assign fifo_pop = !fifo_empty &&
                      ((state == IDLE) ||
                       (hold_end && ((head_dev == cur_dev) || (head_dev == 2'b00))));

    assign {flash_csn, sdcard_csn, lcd_csn} = csn_vec;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign state_dbg = state;

    function automatic logic [2:0] csn_select(input logic [1:0] dev);
        case (dev)
            2'b01:   return 3'b110;
            2'b10:   return 3'b101;
            2'b11:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    always_ff @(posedge Bus2IP_Clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state    <= IDLE;
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cur_dev  <= 2'b00;
            csn_vec  <= 3'b111;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    if (!fifo_empty && (head_dev != 2'b00)) begin
                        cur_dev <= head_dev;
                        csn_vec <= csn_select(head_dev);
                        tx_sh   <= fifo_head[7:0];
                        mosi    <= fifo_head[7];
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        sck      <= 1'b1;
                        rx_sh    <= {rx_sh[6:0], miso};
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    // Even half-periods are sck high; the final (15th) low half leads into HOLD.
                    if (div_done) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 1'b1;
                        if (half_cnt == 4'd15) begin
                            state <= HOLD;
                        end else if (!half_cnt[0]) begin
                            sck   <= 1'b0;
                            tx_sh <= {tx_sh[6:0], 1'b0};
                            mosi  <= tx_sh[6];
                        end else begin
                            sck   <= 1'b1;
                            rx_sh <= {rx_sh[6:0], miso};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        div_cnt  <= '0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh;
                        if (!fifo_empty && (head_dev == cur_dev)) begin
                            tx_sh <= fifo_head[7:0];
                            mosi  <= fifo_head[7];
                            state <= SETUP;
                        end else begin
                            csn_vec <= 3'b111;
                            state   <= GAP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    csn_vec <= 3'b111;
                    sck     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: drivers push commands and expected bytes into exp_q,
// a negedge monitor pops and compares on every rx_valid and watches chip-select timing.
module tb_spi_shift_engine;
    localparam int CLK_DIV     = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int XFER_CYCLES = 18 * CLK_DIV;

    logic       tb_Bus2IP_Clk = 1'b0;
    logic       tb_Bus2IP_Resetn;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       lcd_csn;
    logic       sdcard_csn;
    logic       flash_csn;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic [2:0] state_dbg;

    logic miso_val;
    logic loopback;
    assign miso = loopback ? mosi : miso_val;

    always #5 tb_Bus2IP_Clk = ~tb_Bus2IP_Clk;

    spi_shift_engine #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Bus2IP_Clk    (tb_Bus2IP_Clk),
        .Bus2IP_Resetn (tb_Bus2IP_Resetn),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .busy          (busy),
        .lcd_csn       (lcd_csn),
        .sdcard_csn    (sdcard_csn),
        .flash_csn     (flash_csn),
        .sck           (sck),
        .mosi          (mosi),
        .miso          (miso),
        .state_dbg     (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int total_exp = 0;
    int rx_count = 0;

    // Entry layout: {device[1:0], tx byte[7:0], expected rx byte[7:0]}.
    logic [17:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] dev_of(input logic [2:0] csn);
        case (csn)
            3'b110:  return 2'b01;
            3'b101:  return 2'b10;
            3'b011:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    logic [2:0]  mon_csn;
    logic        any_low;
    logic        prev_any_low;
    logic        prev_sck;
    logic [7:0]  mon_tx;
    logic [1:0]  mon_dev;
    logic [17:0] mon_exp;
    int pulses, lat, low_run, last_low, high_run, last_gap;

    always @(negedge tb_Bus2IP_Clk) begin
        mon_csn = {flash_csn, sdcard_csn, lcd_csn};
        if (!tb_Bus2IP_Resetn) begin
            pulses       = 0;
            lat          = 0;
            low_run      = 0;
            high_run     = 0;
            prev_sck     = 1'b0;
            prev_any_low = 1'b0;
        end else begin
            any_low = (mon_csn != 3'b111);
            check("csn_more_than_one_low", 32'($countones(~mon_csn) > 1), 32'(0));
            if (!any_low) check("sck_low_without_cs", 32'(sck), 32'(0));
            if (sck && !prev_sck) begin
                mon_tx  = {mon_tx[6:0], mosi};
                mon_dev = dev_of(mon_csn);
                pulses++;
            end
            if (any_low && !prev_any_low) begin
                lat      = 0;
                last_gap = high_run;
            end else begin
                lat++;
            end
            if (any_low) begin
                low_run++;
                high_run = 0;
            end else begin
                if (prev_any_low) last_low = low_run;
                low_run = 0;
                high_run++;
            end
            if (rx_valid) begin
                rx_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rx_valid: got rx_data 0x%0h, expected no rx_valid at %0t",
                             rx_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(mon_exp[7:0]));
                    check("mosi_byte", 32'(mon_tx), 32'(mon_exp[15:8]));
                    check("device", 32'(mon_dev), 32'(mon_exp[17:16]));
                    check("sck_pulses", pulses, 8);
                    check("csn_to_rx_valid", lat, XFER_CYCLES);
                end
                pulses = 0;
                lat    = 0;
            end
            prev_sck     = sck;
            prev_any_low = any_low;
        end
    end

    task automatic push_cmd(input logic [9:0] d, input logic [7:0] rx_exp);
        int guard;
        guard = 0;
        @(negedge tb_Bus2IP_Clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && guard < 2000) begin
            @(negedge tb_Bus2IP_Clk);
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: got cmd_ready 0 for %0d cycles, expected 1", guard);
        end
        @(posedge tb_Bus2IP_Clk);
        if (d[9:8] != 2'b00) begin
            exp_q.push_back({d, rx_exp});
            total_exp++;
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge tb_Bus2IP_Clk);
        while (busy && guard < 3000) begin
            @(negedge tb_Bus2IP_Clk);
            guard++;
        end
        if (guard >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy 1 after %0d cycles, expected 0", guard);
        end
        repeat (2) @(negedge tb_Bus2IP_Clk);
    endtask

    task automatic wait_cs_low();
        int guard;
        guard = 0;
        @(negedge tb_Bus2IP_Clk);
        while ({flash_csn, sdcard_csn, lcd_csn} == 3'b111 && guard < 500) begin
            @(negedge tb_Bus2IP_Clk);
            guard++;
        end
        if (guard >= 500) begin
            checks++;
            errors++;
            $display("FAIL cs_low_timeout: got all csn 1 for %0d cycles, expected a select", guard);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_csn"}, 32'({flash_csn, sdcard_csn, lcd_csn}), 32'(3'b111));
        check({tag, "_sck"}, 32'(sck), 32'(0));
        check({tag, "_mosi"}, 32'(mosi), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'(0));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(0));
        check({tag, "_state"}, 32'(state_dbg), 32'(0));
    endtask

    logic [9:0] burst [6] = '{10'h122, 10'h133, 10'h244, 10'h355, 10'h166, 10'h177};
    int   acc;
    logic ready_seen;

    initial begin
        tb_Bus2IP_Resetn = 1'b0;
        cmd_valid        = 1'b0;
        cmd_data         = '0;
        miso_val         = 1'b0;
        loopback         = 1'b0;
        repeat (3) @(posedge tb_Bus2IP_Clk);
        @(negedge tb_Bus2IP_Clk);
        check_reset_state("reset");
        tb_Bus2IP_Resetn = 1'b1;

        // Single LCD byte, miso held high.
        miso_val = 1'b1;
        push_cmd(10'h1FF, 8'hFF);
        wait_idle();
        check("lcd_csn_low_single", last_low, XFER_CYCLES);

        // Two LCD bytes back-to-back under one chip select.
        push_cmd(10'h1FF, 8'hFF);
        push_cmd(10'h15A, 8'hFF);
        wait_idle();
        check("lcd_csn_low_double", last_low, 2 * XFER_CYCLES);

        // Device change: GAP state plus the IDLE dispatch cycle keeps all csn high.
        loopback = 1'b1;
        push_cmd(10'h1A5, 8'hA5);
        push_cmd(10'h2A5, 8'hA5);
        wait_idle();
        check("device_change_gap", last_gap, CLK_DIV + 1);

        // Flash with mosi looped to miso.
        push_cmd(10'h33C, 8'h3C);
        wait_idle();

        // Release command consumed in IDLE, then an SD byte.
        push_cmd(10'h000, 8'h00);
        push_cmd(10'h2C3, 8'hC3);
        wait_idle();

        // Release command at the FIFO head when HOLD ends splits two LCD frames.
        push_cmd(10'h155, 8'h55);
        push_cmd(10'h000, 8'h00);
        push_cmd(10'h156, 8'h56);
        wait_idle();
        check("release_split_gap", last_gap, CLK_DIV + 1);
        check("release_split_low", last_low, XFER_CYCLES);

        // Hold cmd_valid for six commands while the first transfer is in flight.
        push_cmd(10'h111, 8'h11);
        wait_cs_low();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge tb_Bus2IP_Clk);
            cmd_valid  = 1'b1;
            cmd_data   = burst[acc];
            ready_seen = cmd_ready;
            @(posedge tb_Bus2IP_Clk);
            if (ready_seen) begin
                exp_q.push_back({burst[acc], burst[acc][7:0]});
                total_exp++;
                acc++;
            end
        end
        #1 cmd_valid = 1'b0;
        @(negedge tb_Bus2IP_Clk);
        check("cmd_ready_when_full", 32'(cmd_ready), 32'(0));
        check("accepted_count", acc, FIFO_DEPTH);
        check("busy_when_full", 32'(busy), 32'(1));
        wait_idle();

        // Reset ten cycles into a transfer aborts it without an rx_valid.
        push_cmd(10'h1C7, 8'hC7);
        wait_cs_low();
        repeat (9) @(posedge tb_Bus2IP_Clk);
        #1 tb_Bus2IP_Resetn = 1'b0;
        void'(exp_q.pop_back());
        total_exp--;
        @(posedge tb_Bus2IP_Clk);
        @(negedge tb_Bus2IP_Clk);
        check_reset_state("abort");
        tb_Bus2IP_Resetn = 1'b1;
        repeat (60) @(negedge tb_Bus2IP_Clk);

        push_cmd(10'h2E1, 8'hE1);
        wait_idle();

        check("expected_left", exp_q.size(), 0);
        check("rx_valid_count", rx_count, total_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish by %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
